freq_estimator: RTL

FREQ_ESTIMATOR -- requirements
Module: freq_estimator

---
 rtl/freq_estimator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/freq_estimator.sv
`default_nettype none
// ============================================================================
// Module      : freq_estimator
// Description : Zero-crossing period measurement on a strobed audio stream,
//               followed by a bit-serial restoring divide that turns the
//               period P into a phase increment floor(2^32 / P).
// Revision    : 1.0 - initial release
// ============================================================================
module freq_estimator #(
    parameter int unsigned        PW         = 20,
    parameter logic signed [31:0] HYST       = 32'sd16777216,
    parameter int unsigned        MIN_PERIOD = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                step_in,
    input  logic signed [31:0]  sample_in,
    output logic [31:0]         incr_out,
    output logic [PW-1:0]       period_out,
    output logic                valid_out,
    output logic                lock_out,
    output logic                busy_out,
    output logic                overrun_out
);

    localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] CNT_TOP = {{(PW-1){1'b1}}, 1'b0};
    localparam logic [PW-1:0] CNT_ONE = PW'(1);
    localparam logic [PW:0]   MIN_P   = (PW+1)'(MIN_PERIOD);
    localparam logic [5:0]    LAST_BIT = 6'd32;

    // S_LOAD is the one-cycle hand-off between accepting a crossing and
    // starting the divide; it counts as busy for overrun purposes.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t          state_q;
    logic            armed_q;
    logic            have_ref_q;
    logic [PW-1:0]   cnt_q;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   rem_q;
    logic [30:0]     quo_q;
    logic [5:0]      bit_q;
    logic [31:0]     incr_q;
    logic [PW-1:0]   period_q;
    logic            valid_q;
    logic            lock_q;
    logic            busy_q;
    logic            overrun_q;

    logic            crossing;
    logic            below_hyst;
    logic [PW:0]     p_meas;
    logic            accept;
    logic            timeout;
    logic [PW:0]     rem_sh;
    logic            rem_ge;
    logic [PW-1:0]   rem_d;
    logic [31:0]     quo_d;

    // Strobe-side decode: crossing, measured period, acceptance and timeout;
    // plus one restoring-division step on the current remainder.
    always_comb begin
        below_hyst = (sample_in < -HYST);
        crossing   = step_in & armed_q & ~sample_in[31];
        p_meas     = {1'b0, cnt_q} + {{PW{1'b0}}, 1'b1};
        accept     = crossing & have_ref_q & (p_meas >= MIN_P);
        timeout    = step_in & ~crossing & (cnt_q == CNT_TOP);
        // Dividend is 2^32: only the first of the 33 bits shifted in is a one.
        rem_sh     = {rem_q, (bit_q == 6'd0)};
        rem_ge     = (rem_sh >= {1'b0, p_q});
        // The true difference is below P, so PW-bit modular subtraction is exact.
        rem_d      = rem_ge ? (rem_sh[PW-1:0] - p_q) : rem_sh[PW-1:0];
        quo_d      = {quo_q, rem_ge};
    end

    // Hysteresis, period counter, divider FSM and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            have_ref_q <= 1'b0;
            cnt_q      <= '0;
            p_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            bit_q      <= '0;
            incr_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;

            if (step_in) begin
                if (crossing) begin
                    armed_q    <= 1'b0;
                    cnt_q      <= '0;
                    have_ref_q <= 1'b1;
                end else begin
                    if (below_hyst) begin
                        armed_q <= 1'b1;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            end

            if (accept && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            if (timeout) begin
                // Signal lost: drop the estimate and any divide in flight.
                have_ref_q <= 1'b0;
                incr_q     <= '0;
                lock_q     <= 1'b0;
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            p_q     <= p_meas[PW-1:0];
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        rem_q   <= '0;
                        quo_q   <= '0;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_DIV;
                    end
                    S_DIV: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d[30:0];
                        bit_q <= bit_q + 6'd1;
                        if (bit_q == LAST_BIT) begin
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                            incr_q   <= quo_d;
                            period_q <= p_q;
                            valid_q  <= 1'b1;
                            lock_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign incr_out    = incr_q;
    assign period_out  = period_q;
    assign valid_out   = valid_q;
    assign lock_out    = lock_q;
    assign busy_out    = busy_q;
    assign overrun_out = overrun_q;

endmodule
`default_nettype wire
